// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants and position type for the sprite window pipeline
package sprite_pkg;

  // Default screen geometry (VGA 640x480 active area)
  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;

  // Default sprite window geometry and image memory layout
  localparam int DEF_NUM_SPR     = 4;
  localparam int DEF_SPR_W       = 64;
  localparam int DEF_SPR_H       = 48;
  localparam int DEF_IMG_STRIDE  = 640;
  localparam int DEF_ADDR_OFFSET = 1;

  // Coordinate and image address widths
  localparam int COORD_W = 10;
  localparam int ADDR_W  = 19;

  // One sprite window: enable plus top-left corner
  typedef struct packed {
    logic               on;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } sprite_pos_t;

endpackage

// File: rtl/sprite_hit_cell.sv
// rtl/sprite_hit_cell.sv - per-sprite window compare with registered hit and offsets
module sprite_hit_cell
  import sprite_pkg::*;
#(
  parameter int SPR_W = DEF_SPR_W,
  parameter int SPR_H = DEF_SPR_H
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [COORD_W-1:0] col,
  input  logic [COORD_W-1:0] row,
  input  sprite_pos_t        pos,
  output logic               hit,
  output logic [COORD_W-1:0] dx,
  output logic [COORD_W-1:0] dy
);

  // Window extents are one bit wider so a sprite hanging off the right or
  // bottom edge clips instead of wrapping back to small coordinates.
  localparam logic [COORD_W:0] SPR_W_EXT = (COORD_W+1)'(SPR_W);
  localparam logic [COORD_W:0] SPR_H_EXT = (COORD_W+1)'(SPR_H);

  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;
  logic             in_win;

  assign x_end  = {1'b0, pos.x} + SPR_W_EXT;
  assign y_end  = {1'b0, pos.y} + SPR_H_EXT;
  assign in_win = pos.on
                  && (col >= pos.x) && ({1'b0, col} < x_end)
                  && (row >= pos.y) && ({1'b0, row} < y_end);

  // Stage-1 register: window membership and offsets into the sprite image
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit <= 1'b0;
      dx  <= '0;
      dy  <= '0;
    end else begin
      hit <= in_win;
      dx  <= col - pos.x;
      dy  <= row - pos.y;
    end
  end

endmodule

// File: rtl/sprite_window_pipe.sv
// rtl/sprite_window_pipe.sv - two-stage sprite window locator emitting sprite image addresses
module sprite_window_pipe #(
  parameter int SCREEN_W    = sprite_pkg::DEF_SCREEN_W,
  parameter int SCREEN_H    = sprite_pkg::DEF_SCREEN_H,
  parameter int NUM_SPR     = sprite_pkg::DEF_NUM_SPR,
  parameter int SPR_W       = sprite_pkg::DEF_SPR_W,
  parameter int SPR_H       = sprite_pkg::DEF_SPR_H,
  parameter int IMG_STRIDE  = sprite_pkg::DEF_IMG_STRIDE,
  parameter int ADDR_OFFSET = sprite_pkg::DEF_ADDR_OFFSET,
  parameter int COORD_W     = sprite_pkg::COORD_W,
  parameter int ADDR_W      = sprite_pkg::ADDR_W,
  parameter int IDX_W       = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic               frame_start,
  input  logic               pos_wr_en,
  input  logic [IDX_W-1:0]   pos_wr_idx,
  input  logic [COORD_W-1:0] pos_wr_x,
  input  logic [COORD_W-1:0] pos_wr_y,
  input  logic               pos_wr_on,
  output logic               out_valid,
  output logic               out_hit,
  output logic [IDX_W-1:0]   out_idx,
  output logic [ADDR_W-1:0]  out_addr
);

  import sprite_pkg::*;

  logic               commit;
  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] cur_col;
  logic [COORD_W-1:0] cur_row;

  sprite_pos_t        wr_pos;
  sprite_pos_t        shadow    [NUM_SPR];
  sprite_pos_t        active    [NUM_SPR];
  sprite_pos_t        active_nx [NUM_SPR];

  logic [NUM_SPR-1:0] hit_v;
  logic [COORD_W-1:0] dx_a [NUM_SPR];
  logic [COORD_W-1:0] dy_a [NUM_SPR];
  logic               v1;

  logic               any_hit;
  logic [IDX_W-1:0]   win_idx;
  logic [COORD_W-1:0] win_dx;
  logic [COORD_W-1:0] win_dy;
  logic [ADDR_W-1:0]  addr_c;

  // A frame_start only counts when it qualifies a real pixel
  assign commit  = pix_valid & frame_start;
  assign cur_col = commit ? '0 : col;
  assign cur_row = commit ? '0 : row;
  assign wr_pos  = {pos_wr_on, pos_wr_x, pos_wr_y};

  // Screen position counters: advance per accepted pixel, raster wrap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (cur_col == COORD_W'(SCREEN_W - 1)) begin
        col <= '0;
        row <= (cur_row == COORD_W'(SCREEN_H - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col <= cur_col + 1'b1;
        row <= cur_row;
      end
    end
  end

  // Active set seen by this pixel: on commit take the shadow, with a
  // same-cycle write forwarded so the newest value wins
  always_comb begin
    for (int i = 0; i < NUM_SPR; i++) begin
      active_nx[i] = active[i];
      if (commit) begin
        if (pos_wr_en && (pos_wr_idx == IDX_W'(i)))
          active_nx[i] = wr_pos;
        else
          active_nx[i] = shadow[i];
      end
    end
  end

  // Shadow and active position registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SPR; i++) begin
        if (pos_wr_en && (pos_wr_idx == IDX_W'(i)))
          shadow[i] <= wr_pos;
        active[i] <= active_nx[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_cell
    sprite_hit_cell #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H)
    ) u_cell (
      .clock (clock),
      .reset (reset),
      .col   (cur_col),
      .row   (cur_row),
      .pos   (active_nx[g]),
      .hit   (hit_v[g]),
      .dx    (dx_a[g]),
      .dy    (dy_a[g])
    );
  end

  // Stage-1 valid bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) v1 <= 1'b0;
    else       v1 <= pix_valid;
  end

  // Priority select: scanning downward leaves the lowest hitting index
  always_comb begin
    any_hit = 1'b0;
    win_idx = '0;
    win_dx  = '0;
    win_dy  = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hit_v[i]) begin
        any_hit = 1'b1;
        win_idx = IDX_W'(i);
        win_dx  = dx_a[i];
        win_dy  = dy_a[i];
      end
    end
  end

  assign addr_c = ADDR_W'(win_dy) * ADDR_W'(IMG_STRIDE)
                + ADDR_W'(win_dx) + ADDR_W'(ADDR_OFFSET);

  // Stage-2 output register; idx/addr are forced to 0 unless a valid hit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_idx   <= '0;
      out_addr  <= '0;
    end else begin
      out_valid <= v1;
      if (v1 && any_hit) begin
        out_hit  <= 1'b1;
        out_idx  <= win_idx;
        out_addr <= addr_c;
      end else begin
        out_hit  <= 1'b0;
        out_idx  <= '0;
        out_addr <= '0;
      end
    end
  end

endmodule

// File: doc/sprite_window_pipe.md
Name: sprite_window_pipe

Overview:
- Pipelined, parametrised sprite-window locator for the VGA pixel stream.
- Tracks the current screen column/row with counters; no divide or modulo on a linear address.
- Tests NUM_SPR independently positioned sprite windows per pixel and selects the highest-priority hit (lowest index).
- Emits the sprite-image memory address. Sits between the VGA timing/address generator and the sprite ROM/colour mux.
- Sprite positions are double-buffered and commit only at frame start, so positions never tear mid-frame.

Parameters:
- SCREEN_W, 640, active pixels per line.
- SCREEN_H, 480, active lines per frame.
- NUM_SPR, 4, number of sprite windows (1..16).
- SPR_W, 64, sprite window width in pixels.
- SPR_H, 48, sprite window height in lines.
- IMG_STRIDE, 640, image-memory words per sprite row.
- ADDR_OFFSET, 1, constant added to every image address.
- COORD_W, 10, width of x/y coordinates.
- ADDR_W, 19, image address width.
- IDX_W, 2, sprite index width (clog2 of NUM_SPR, minimum 1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pix_valid  in  1  one pixel presented this cycle.
- frame_start  in  1  qualifies the current pixel as screen (0,0); meaningful only with pix_valid.
- pos_wr_en  in  1  write the shadow position of sprite pos_wr_idx.
- pos_wr_idx  in  IDX_W  sprite being written.
- pos_wr_x  in  COORD_W  new left edge.
- pos_wr_y  in  COORD_W  new top edge.
- pos_wr_on  in  1  new enable bit.
- out_valid  out  1  pipeline result valid.
- out_hit  out  1  pixel lies inside at least one enabled window.
- out_idx  out  IDX_W  winning sprite index.
- out_addr  out  ADDR_W  image address for the winning sprite.

Behaviour:
- Reset (asynchronous):
  - Counters go to (0,0).
  - Shadow and active position registers go to 0 with all sprites disabled.
  - Pipeline valid bits clear; all outputs are 0.
- Pixel coordinate for the current pixel:
  - If pix_valid and frame_start, it is (0,0).
  - Otherwise it is the counter value.
- Counter update, on a pix_valid cycle only:
  - col advances to current col+1, wrapping to 0 at SCREEN_W-1.
  - On col wrap, row advances, wrapping to 0 at SCREEN_H-1.
  - pix_valid low: counters hold.
  - frame_start without pix_valid is ignored: no counter change, no commit.
- Commit: on a pix_valid and frame_start cycle, every active register loads its shadow. That first pixel already uses the committed values.
- Shadow write:
  - pos_wr_en writes the shadow entry the next edge.
  - A write coinciding with a commit on the same index forwards the written value into active, so the write wins.
  - Writes are legal at any time.
- Stage 1, registered, per sprite i:
  - in = on_i and col>=x_i and col<x_i+SPR_W and row>=y_i and row<y_i+SPR_H.
  - Sums are computed at COORD_W+1 bits, so windows past the right or bottom edge clip and never wrap.
  - dx = col-x_i and dy = row-y_i are also registered.
- Stage 2, registered:
  - Lowest-index set "in" wins.
  - out_addr = dy*IMG_STRIDE + dx + ADDR_OFFSET, truncated to ADDR_W.
- Latency and flow:
  - A pixel accepted at edge t appears on outputs after edge t+2.
  - No stall; out_valid is pix_valid delayed exactly 2.
  - When out_valid=0 or out_hit=0: out_idx=0 and out_addr=0.
- Reset mid-frame: in-flight pixels are discarded. The stream restarts at (0,0) on the next pix_valid, with or without frame_start.

Decomposition:
- Package sprite_pkg holds:
  - default screen and sprite dimension constants;
  - COORD_W and ADDR_W;
  - typedef sprite_pos_t {on, x, y}.
- One sub-module, sprite_hit_cell: per-sprite compare plus dx/dy, stage-1 registers included, instantiated NUM_SPR times.
- Priority select and address multiply stay in the top level.

Test Plan:
- Sprite 0 at (100,50) on, committed by frame_start:
  - pixel (100,50) -> hit=1, idx=0, addr=1;
  - pixel (163,97) -> addr=30144;
  - pixels (164,50) and (99,50) -> hit=0.
- Overlap, spr0 (100,50) and spr2 (120,60), pixel (130,70):
  - idx=0, addr=12831;
  - after disabling spr0 and the next commit -> idx=2, addr=6411.
- Edge clip, spr1 at (600,460):
  - pixel (639,479) -> hit, addr=12200;
  - next pixel wraps to (0,0) -> hit=0;
  - pixel (40,0) -> hit=0.
- Double buffer:
  - set spr0 x=200 mid-frame -> remainder of frame still hits at x=100;
  - next frame hits at x=200;
  - a write issued on the frame_start cycle applies to that same pixel (0,0), e.g. sprite placed at (0,0) -> hit, addr=1.
- Random pix_valid gaps plus a stray frame_start with pix_valid=0:
  - counters unaffected;
  - out_valid matches pix_valid delayed 2;
  - addresses match the model.
- Reset asserted mid-frame:
  - outputs 0 immediately;
  - out_valid stays 0 until 2 edges after the first post-reset pix_valid;
  - first pixel is treated as (0,0).
